game_round_scheduler: RTL and testbench

- Match-level controller above the game master FSM. It runs a match of ROUNDS_PER_GAME rounds.
- Each round it gates the master with round_enable and detects the round's end from the end-of-game timer. It then tallies wins and raises a difficulty level that configures target sprite speed.
- It inserts a fixed pause between rounds and flags match completion and outcome for display logic.

---
 rtl/game_round_scheduler.sv | 134 +++++++++++++
 tb/tb_game_round_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_scheduler.sv
// Match-level controller: gates the game master round by round, tallies wins,
// raises difficulty and flags match completion/outcome.
module game_round_scheduler #(
  parameter int unsigned ROUNDS_PER_GAME = 8,
  parameter int unsigned ROUND_W         = 4,
  parameter int unsigned SCORE_W         = 4,
  parameter int unsigned LEVEL_W         = 2,
  parameter int unsigned WIN_THRESHOLD   = 5,
  parameter int unsigned PAUSE_CYCLES    = 16,
  parameter int unsigned PAUSE_W         = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_key,
  input  logic               end_of_game_timer_running,
  input  logic               game_won,
  output logic               round_enable,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score,
  output logic [ROUND_W-1:0] rounds_played,
  output logic               round_tally,
  output logic               match_over,
  output logic               match_won
);

  typedef enum logic [2:0] {StIdle, StPlay, StTally, StPause, StOver} state_e;

  state_e               state_q, state_d;
  logic                 start_q, timer_q;
  logic                 won_q, won_d;
  logic [PAUSE_W-1:0]   pause_q, pause_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [ROUND_W-1:0]   rounds_q, rounds_d;
  logic                 enable_q, enable_d;
  logic                 tally_q, tally_d;
  logic                 over_q, over_d;
  logic                 mwon_q, mwon_d;
  logic                 start_rise, timer_fall;

  assign start_rise = start_key & ~start_q;
  assign timer_fall = ~end_of_game_timer_running & timer_q;

  always_comb begin
    state_d  = state_q;
    won_d    = won_q;
    pause_d  = pause_q;
    score_d  = score_q;
    level_d  = level_q;
    rounds_d = rounds_q;
    over_d   = over_q;
    mwon_d   = mwon_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          score_d  = '0;
          level_d  = '0;
          rounds_d = '0;
          over_d   = 1'b0;
          mwon_d   = 1'b0;
          state_d  = StPlay;
        end
      end
      StPlay: begin
        if (timer_fall) begin
          won_d   = game_won;
          state_d = StTally;
        end
      end
      StTally: begin
        rounds_d = rounds_q + ROUND_W'(1);
        if (won_q) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          if (level_q != '1) level_d = level_q + LEVEL_W'(1);
        end
        // Outcome uses the post-tally score so it is valid on the OVER entry edge.
        if (rounds_d == ROUND_W'(ROUNDS_PER_GAME)) begin
          over_d  = 1'b1;
          mwon_d  = (int'(score_d) >= int'(WIN_THRESHOLD));
          state_d = StOver;
        end else begin
          pause_d = PAUSE_W'(PAUSE_CYCLES - 1);
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_q == '0) state_d = StPlay;
        else               pause_d = pause_q - PAUSE_W'(1);
      end
      default: state_d = StIdle;
    endcase
    enable_d = (state_d == StPlay);
    tally_d  = (state_d == StTally);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      timer_q  <= 1'b0;
      won_q    <= 1'b0;
      pause_q  <= '0;
      score_q  <= '0;
      level_q  <= '0;
      rounds_q <= '0;
      enable_q <= 1'b0;
      tally_q  <= 1'b0;
      over_q   <= 1'b0;
      mwon_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_key;
      timer_q  <= end_of_game_timer_running;
      won_q    <= won_d;
      pause_q  <= pause_d;
      score_q  <= score_d;
      level_q  <= level_d;
      rounds_q <= rounds_d;
      enable_q <= enable_d;
      tally_q  <= tally_d;
      over_q   <= over_d;
      mwon_q   <= mwon_d;
    end
  end

  assign round_enable  = enable_q;
  assign level         = level_q;
  assign score         = score_q;
  assign rounds_played = rounds_q;
  assign round_tally   = tally_q;
  assign match_over    = over_q;
  assign match_won     = mwon_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Randomized bench for game_round_scheduler against a win-count reference model.
module tb_game_round_scheduler;

  localparam int unsigned Rounds = 8;
  localparam int unsigned WinThr = 5;
  localparam int unsigned Pause  = 16;
  localparam int unsigned ScoreMax = 15;
  localparam int unsigned LevelMax = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_key = 1'b0;
  logic       timer = 1'b0;
  logic       game_won = 1'b0;
  logic       round_enable;
  logic [1:0] level;
  logic [3:0] score;
  logic [3:0] rounds_played;
  logic       round_tally;
  logic       match_over;
  logic       match_won;

  int checks = 0;
  int errors = 0;
  int m_wins = 0;
  int m_rounds = 0;

  game_round_scheduler dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .start_key                 (start_key),
    .end_of_game_timer_running (timer),
    .game_won                  (game_won),
    .round_enable              (round_enable),
    .level                     (level),
    .score                     (score),
    .rounds_played             (rounds_played),
    .round_tally               (round_tally),
    .match_over                (match_over),
    .match_won                 (match_won)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".score"}, 32'(score), sat(m_wins, ScoreMax));
    check({tag, ".level"}, 32'(level), sat(m_wins, LevelMax));
    check({tag, ".rounds"}, 32'(rounds_played), m_rounds);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".en"}, 32'(round_enable), 0);
    check({tag, ".level"}, 32'(level), 0);
    check({tag, ".score"}, 32'(score), 0);
    check({tag, ".rounds"}, 32'(rounds_played), 0);
    check({tag, ".tally"}, 32'(round_tally), 0);
    check({tag, ".over"}, 32'(match_over), 0);
    check({tag, ".mwon"}, 32'(match_won), 0);
  endtask

  // One round: timer runs k cycles then falls; checks tally timing, counters and pause length.
  task automatic play_round(input bit won, input bit last);
    int k;
    k = $urandom_range(1, 12);
    timer = 1'b1;
    for (int i = 0; i < k; i++) begin
      tick();
      check("play.en", 32'(round_enable), 1);
      check("play.tally", 32'(round_tally), 0);
    end
    timer = 1'b0;
    game_won = won;
    tick();
    check("tally.pulse", 32'(round_tally), 1);
    check("tally.en", 32'(round_enable), 0);
    check_counters("tally.pre");
    game_won = 1'($urandom_range(0, 1));
    tick();
    m_rounds++;
    if (won) m_wins++;
    check("tally.end", 32'(round_tally), 0);
    check_counters("tally.post");
    if (last) begin
      check("over.flag", 32'(match_over), 1);
      check("over.won", 32'(match_won), (m_wins >= WinThr) ? 1 : 0);
      check("over.en", 32'(round_enable), 0);
    end else begin
      check("pause.over", 32'(match_over), 0);
      for (int i = 0; i < Pause - 1; i++) begin
        timer = (i < Pause - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        check("pause.en", 32'(round_enable), 0);
        check("pause.tally", 32'(round_tally), 0);
      end
      check_counters("pause");
      tick();
      check("pause.resume", 32'(round_enable), 1);
    end
  endtask

  initial begin
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    check_zero("idle");

    // Falling timer in IDLE is ignored
    timer = 1'b1;
    tick();
    timer = 1'b0;
    tick();
    tick();
    check_zero("idle.fall");

    // Start held high 50 cycles: one start only
    start_key = 1'b1;
    tick();
    check("start.en", 32'(round_enable), 1);
    check_counters("start");
    for (int i = 0; i < 49; i++) begin
      tick();
      check("start.held", 32'(round_enable), 1);
    end
    start_key = 1'b0;

    // Match 1: wins in rounds 1..6, losses in 7..8
    for (int r = 0; r < Rounds; r++) play_round(r < 6, r == Rounds - 1);
    check("m1.score", 32'(score), 6);
    check("m1.level", 32'(level), 3);

    // Timer activity in OVER is ignored
    for (int i = 0; i < 10; i++) begin
      timer = 1'($urandom_range(0, 1));
      tick();
      check("over.tally", 32'(round_tally), 0);
      check("over.hold", 32'(match_over), 1);
      check("over.en", 32'(round_enable), 0);
    end
    timer = 1'b0;
    tick();
    check_counters("over.idle");

    // Restart, keeping start_key high through a whole random match
    start_key = 1'b1;
    tick();
    m_wins = 0;
    m_rounds = 0;
    check("restart.en", 32'(round_enable), 1);
    check("restart.over", 32'(match_over), 0);
    check("restart.mwon", 32'(match_won), 0);
    check_counters("restart");
    for (int r = 0; r < Rounds; r++) play_round(1'($urandom_range(0, 1)), r == Rounds - 1);
    repeat (10) tick();
    check("held.over", 32'(match_over), 1);
    check("held.en", 32'(round_enable), 0);
    start_key = 1'b0;
    tick();
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
    m_wins = 0;
    m_rounds = 0;
    check("repress.en", 32'(round_enable), 1);
    check_counters("repress");

    // Async reset mid-PLAY with a fall pending
    timer = 1'b1;
    tick();
    tick();
    timer = 1'b0;
    #3 reset_n = 1'b0;
    #1 check_zero("rst.play");
    tick();
    reset_n = 1'b1;
    timer = 1'b1;
    tick();
    timer = 1'b0;
    tick();
    tick();
    check_zero("rst.play.after");

    // Async reset mid-PAUSE
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
    timer = 1'b1;
    tick();
    timer = 1'b0;
    repeat (5) tick();
    check("pre.rst.pause", 32'(rounds_played), 1);
    #3 reset_n = 1'b0;
    #1 check_zero("rst.pause");
    tick();
    reset_n = 1'b1;
    timer = 1'b1;
    tick();
    timer = 1'b0;
    repeat (3) tick();
    check_zero("rst.pause.after");

    // Fresh random match after reset
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
    m_wins = 0;
    m_rounds = 0;
    check("m3.en", 32'(round_enable), 1);
    for (int r = 0; r < Rounds; r++) play_round(1'($urandom_range(0, 1)), r == Rounds - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
